math_sequencer: RTL and testbench

MATH_SEQUENCER -- requirements
Module: math_sequencer

---
 rtl/math_pkg.sv | 63 ++++++
 rtl/math_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_math_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// math_pkg
//   Shared definitions for the math sequencer: math unit opcodes, macro
//   codes carried in the header byte, the error response byte, the FSM
//   state encoding and a helper that turns the header count field into a
//   clamped byte count.
package math_pkg;

  // Math unit opcodes (00-0D). The sequencer itself only generates NOP,
  // SWAP, CLR, ORB, SHL and SHR; the rest can be issued through PASS.
  localparam logic [7:0] OP_NOP  = 8'h00;  // no operation
  localparam logic [7:0] OP_SWAP = 8'h01;  // toggle accumulator select
  localparam logic [7:0] OP_CLR  = 8'h02;  // clear selected accumulator
  localparam logic [7:0] OP_SET  = 8'h03;
  localparam logic [7:0] OP_ORB  = 8'h04;  // OR operand into low byte
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_AND  = 8'h07;
  localparam logic [7:0] OP_XOR  = 8'h08;
  localparam logic [7:0] OP_NOT  = 8'h09;
  localparam logic [7:0] OP_SHL  = 8'h0A;  // shift left by operand bits
  localparam logic [7:0] OP_ROL  = 8'h0B;
  localparam logic [7:0] OP_SHR  = 8'h0C;  // shift right by operand bits
  localparam logic [7:0] OP_ROR  = 8'h0D;

  // Operand used with SHL/SHR to move the accumulator by one byte.
  localparam logic [7:0] SHIFT_BYTE = 8'h08;

  // Macro codes from header bits [7:4]; every other code is an error.
  localparam logic [3:0] MAC_PASS  = 4'h0;
  localparam logic [3:0] MAC_LOAD0 = 4'h1;
  localparam logic [3:0] MAC_READ0 = 4'h2;

  // Response byte emitted for an unknown macro code.
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic [3:0] {
    IDLE,
    PASS_OP,
    PASS_DATA,
    LD_CLR,
    LD_WAIT,
    LD_SHIFT,
    LD_BYTE,
    RD_SEL,
    RD_SETTLE,
    RD_CAP,
    RD_WAIT,
    RD_SHIFT,
    ERR
  } state_t;

  // Header count field holds N-1; N is limited to the accumulator width.
  function automatic logic [4:0] clamp_count(input logic [3:0] field,
                                             input logic [4:0] max_bytes);
    logic [4:0] n;
    n = {1'b0, field} + 5'd1;
    if (n > max_bytes) begin
      n = max_bytes;
    end
    return n;
  endfunction

endpackage

// File: rtl/math_sequencer.sv
// math_sequencer
//   Turns a byte-oriented command stream into single-cycle opcode/operand
//   pulses for an attached math unit, and streams accumulator bytes back.
//   Macros: PASS (raw op+operand), LOAD0 (load accumulator 0 MSB first),
//   READ0 (destructive read of accumulator 0, LSB first). Unknown macros
//   answer with a single 8'hEE byte.
//
// Parameters
//   BITS        accumulator width of the math unit (multiple of 8, <= 128)
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   cmd_valid   command byte valid
//   cmd_ready   command byte accepted this cycle when cmd_valid=1
//   cmd_data    command byte
//   rsp_valid   response byte valid (held until rsp_ready)
//   rsp_ready   response byte accepted when rsp_valid=1
//   rsp_data    response byte
//   math_op     registered opcode to the math unit (00 when idle)
//   math_data   registered operand to the math unit (00 when idle)
//   math_result low byte of the selected accumulator
module math_sequencer #(
  parameter int BITS = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] math_op,
  output logic [7:0] math_data,
  input  logic [7:0] math_result
);

  import math_pkg::*;

  localparam logic [4:0] MAX_BYTES = 5'(BITS / 8);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       shadow_q, shadow_d;
  logic [7:0] op_hold_q, op_hold_d;
  logic [7:0] byte_hold_q, byte_hold_d;
  logic [7:0] math_op_q, math_op_d;
  logic [7:0] math_data_q, math_data_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       ready_en_q;
  logic       accept;
  logic [4:0] cnt_dec;

  // ready_en_q holds cmd_ready low until the first edge after reset
  // releases, so nothing is accepted while the FSM is still settling.
  assign cmd_ready = ready_en_q &&
                     ((state_q == IDLE)      || (state_q == PASS_OP) ||
                      (state_q == PASS_DATA) || (state_q == LD_WAIT));
  assign accept    = cmd_valid && cmd_ready;

  // Saturating decrement: the counter never wraps below zero.
  assign cnt_dec   = (cnt_q == 5'd0) ? 5'd0 : (cnt_q - 5'd1);

  assign math_op   = math_op_q;
  assign math_data = math_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // State and output registers. Everything returns to its idle value the
  // moment rst_n falls; an interrupted macro is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      shadow_q    <= 1'b0;
      op_hold_q   <= 8'h00;
      byte_hold_q <= 8'h00;
      math_op_q   <= OP_NOP;
      math_data_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      op_hold_q   <= op_hold_d;
      byte_hold_q <= byte_hold_d;
      math_op_q   <= math_op_d;
      math_data_q <= math_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ready_en_q  <= 1'b1;
    end
  end

  // Next-state and issue logic. math_op_d defaults to NOP so any issued
  // op is visible for exactly one cycle; waiting on cmd_valid or
  // rsp_ready just produces NOP cycles without losing or repeating ops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    op_hold_d   = op_hold_q;
    byte_hold_d = byte_hold_q;
    math_op_d   = OP_NOP;
    math_data_d = 8'h00;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_data[7:4])
            MAC_PASS: begin
              state_d = PASS_OP;
            end
            MAC_LOAD0: begin
              cnt_d   = clamp_count(cmd_data[3:0], MAX_BYTES);
              state_d = LD_CLR;
            end
            MAC_READ0: begin
              cnt_d   = clamp_count(cmd_data[3:0], MAX_BYTES);
              // Accumulator 0 must be selected before reading it.
              state_d = shadow_q ? RD_SEL : RD_SETTLE;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = ERR_BYTE;
              state_d     = ERR;
            end
          endcase
        end
      end

      PASS_OP: begin
        if (accept) begin
          op_hold_d = cmd_data;
          state_d   = PASS_DATA;
        end
      end

      PASS_DATA: begin
        if (accept) begin
          math_op_d   = op_hold_q;
          math_data_d = cmd_data;
          // Track the unit's accumulator select even for raw ops.
          if (op_hold_q == OP_SWAP) begin
            shadow_d = ~shadow_q;
          end
          state_d = IDLE;
        end
      end

      LD_CLR: begin
        math_op_d = OP_CLR;
        state_d   = LD_WAIT;
      end

      LD_WAIT: begin
        if (accept) begin
          byte_hold_d = cmd_data;
          state_d     = LD_SHIFT;
        end
      end

      LD_SHIFT: begin
        math_op_d   = OP_SHL;
        math_data_d = SHIFT_BYTE;
        state_d     = LD_BYTE;
      end

      LD_BYTE: begin
        math_op_d   = OP_ORB;
        math_data_d = byte_hold_q;
        cnt_d       = cnt_dec;
        state_d     = (cnt_dec == 5'd0) ? IDLE : LD_WAIT;
      end

      RD_SEL: begin
        math_op_d = OP_SWAP;
        shadow_d  = ~shadow_q;
        state_d   = RD_SETTLE;
      end

      RD_SETTLE: begin
        // Capture only after a full NOP cycle so the last op has landed.
        if (math_op_q == OP_NOP) begin
          state_d = RD_CAP;
        end
      end

      RD_CAP: begin
        rsp_data_d  = math_result;
        rsp_valid_d = 1'b1;
        state_d     = RD_WAIT;
      end

      RD_WAIT: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          math_op_d   = OP_SHR;
          math_data_d = SHIFT_BYTE;
          cnt_d       = cnt_dec;
          state_d     = (cnt_dec == 5'd0) ? IDLE : RD_SHIFT;
        end
      end

      RD_SHIFT: begin
        state_d = RD_SETTLE;
      end

      ERR: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_math_sequencer.sv
// tb_math_sequencer
//   Directed bench for math_sequencer with a small reference math unit.
//   Expected ops and response bytes are queued when stimulus is issued; a
//   monitor pops and compares whenever the DUT issues an op or hands over
//   a response byte.
module tb_math_sequencer;

  localparam int BITS = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [7:0]      cmd_data = 8'h00;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [7:0]      rsp_data;
  logic [7:0]      math_op;
  logic [7:0]      math_data;
  logic [7:0]      math_result;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_op_q[$];
  logic [7:0]  exp_rsp_q[$];

  // Reference math unit: two accumulators, select bit toggled by op 01.
  logic [BITS-1:0] acc0 = '0;
  logic [BITS-1:0] acc1 = '0;
  logic            sel = 1'b0;

  math_sequencer #(.BITS(BITS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .math_op(math_op),
    .math_data(math_data),
    .math_result(math_result)
  );

  always #5 clk = ~clk;

  assign math_result = sel ? acc1[7:0] : acc0[7:0];

  always @(posedge clk) begin
    logic [BITS-1:0] cur;
    logic [BITS-1:0] nxt;
    cur = sel ? acc1 : acc0;
    nxt = cur;
    case (math_op)
      8'h02: nxt = '0;
      8'h04: nxt = cur | BITS'(math_data);
      8'h0A: nxt = cur << math_data;
      8'h0C: nxt = cur >> math_data;
      default: nxt = cur;
    endcase
    if (math_op == 8'h01) begin
      sel <= ~sel;
    end else if (sel) begin
      acc1 <= nxt;
    end else begin
      acc0 <= nxt;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (math_op != 8'h00) begin
        if (exp_op_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_op: got %h/%h, required no op",
                   math_op, math_data);
        end else begin
          check_output("op_trace", {16'h0, math_op, math_data},
                       {16'h0, exp_op_q.pop_front()});
        end
      end
      if (rsp_valid) begin
        if (prev_stall) begin
          check_output("rsp_stable", {24'h0, rsp_data}, {24'h0, prev_data});
        end
        if (rsp_ready) begin
          if (exp_rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got %h, required none", rsp_data);
          end else begin
            check_output("rsp_byte", {24'h0, rsp_data},
                         {24'h0, exp_rsp_q.pop_front()});
          end
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic expect_op(input logic [7:0] op, input logic [7:0] d);
    exp_op_q.push_back({op, d});
  endtask

  // Present one command byte and hold it until the DUT takes it.
  task automatic apply_stimulus(input logic [7:0] b);
    bit taken = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    for (int i = 0; i < 100 && !taken; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        taken = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept: byte %h not taken, required taken", b);
    end
  endtask

  // Wait for all queued expectations to be consumed, bounded.
  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (exp_op_q.size() == 0 && exp_rsp_q.size() == 0) break;
    end
    if (exp_op_q.size() != 0 || exp_rsp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d ops, %0d rsps left, required 0",
               exp_op_q.size(), exp_rsp_q.size());
      exp_op_q.delete();
      exp_rsp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load0_two(input logic [7:0] hdr, input logic [7:0] b1,
                           input logic [7:0] b0);
    expect_op(8'h02, 8'h00);
    expect_op(8'h0A, 8'h08);
    expect_op(8'h04, b1);
    expect_op(8'h0A, 8'h08);
    expect_op(8'h04, b0);
    apply_stimulus(hdr);
    apply_stimulus(b1);
    apply_stimulus(b0);
    wait_drain();
  endtask

  initial begin
    // Reset state, and cmd_ready staying low until the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_math_op", {24'h0, math_op}, 32'h0);
    check_output("rst_math_data", {24'h0, math_data}, 32'h0);
    check_output("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_output("rst_rsp_data", {24'h0, rsp_data}, 32'h0);
    check_output("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check_output("ready_after_release", {31'h0, cmd_ready}, 32'h0);
    @(posedge clk);
    #1 check_output("ready_first_edge", {31'h0, cmd_ready}, 32'h1);

    // LOAD0 12 34.
    load0_two(8'h11, 8'h12, 8'h34);
    check_output("load0_acc0", 32'(acc0), 32'h1234);

    // READ0 N=2: LSB first, destructive.
    exp_rsp_q.push_back(8'h34);
    expect_op(8'h0C, 8'h08);
    exp_rsp_q.push_back(8'h12);
    expect_op(8'h0C, 8'h08);
    apply_stimulus(8'h21);
    wait_drain();
    check_output("read0_acc0_cleared", 32'(acc0), 32'h0);

    // LOAD0 N=1 5A, PASS 01/00, then READ0 N=1 must reselect accum0.
    expect_op(8'h02, 8'h00);
    expect_op(8'h0A, 8'h08);
    expect_op(8'h04, 8'h5A);
    apply_stimulus(8'h10);
    apply_stimulus(8'h5A);
    wait_drain();
    expect_op(8'h01, 8'h00);
    apply_stimulus(8'h00);
    apply_stimulus(8'h01);
    apply_stimulus(8'h00);
    wait_drain();
    check_output("pass_sel", {31'h0, sel}, 32'h1);
    expect_op(8'h01, 8'h00);
    exp_rsp_q.push_back(8'h5A);
    expect_op(8'h0C, 8'h08);
    apply_stimulus(8'h20);
    wait_drain();
    check_output("read_sel_back", {31'h0, sel}, 32'h0);
    check_output("read_sel_acc0", 32'(acc0), 32'h0);

    // READ0 N=2 with rsp_ready held low for 5 cycles.
    load0_two(8'h11, 8'hAB, 8'hCD);
    rsp_ready = 1'b0;
    exp_rsp_q.push_back(8'hCD);
    expect_op(8'h0C, 8'h08);
    exp_rsp_q.push_back(8'hAB);
    expect_op(8'h0C, 8'h08);
    apply_stimulus(8'h21);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(posedge clk);
    #1;
    check_output("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    check_output("stall_acc0_intact", 32'(acc0), 32'hABCD);
    check_output("stall_rsp_data", {24'h0, rsp_data}, 32'hCD);
    rsp_ready = 1'b1;
    wait_drain();
    check_output("stall_acc0_cleared", 32'(acc0), 32'h0);

    // Unknown macro: single EE response, then a header is accepted.
    exp_rsp_q.push_back(8'hEE);
    apply_stimulus(8'h70);
    wait_drain();
    expect_op(8'h02, 8'h00);
    expect_op(8'h0A, 8'h08);
    expect_op(8'h04, 8'h77);
    apply_stimulus(8'h10);
    apply_stimulus(8'h77);
    wait_drain();
    check_output("after_err_acc0", 32'(acc0), 32'h0077);

    // Count clamp: N=3 and N=16 both limited to 2 bytes for 16 bits.
    load0_two(8'h12, 8'h56, 8'h78);
    check_output("clamp_load_acc0", 32'(acc0), 32'h5678);
    exp_rsp_q.push_back(8'h78);
    expect_op(8'h0C, 8'h08);
    exp_rsp_q.push_back(8'h56);
    expect_op(8'h0C, 8'h08);
    apply_stimulus(8'h2F);
    wait_drain();
    check_output("clamp_read_acc0", 32'(acc0), 32'h0);

    // Reset pulsed while waiting in LD_WAIT, then a clean LOAD0.
    expect_op(8'h02, 8'h00);
    apply_stimulus(8'h11);
    @(posedge clk);
    @(negedge clk);
    check_output("ldwait_ready", {31'h0, cmd_ready}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_output("midrst_math_op", {24'h0, math_op}, 32'h0);
    check_output("midrst_math_data", {24'h0, math_data}, 32'h0);
    check_output("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_output("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check_output("midrst_ready_low", {31'h0, cmd_ready}, 32'h0);
    wait_drain();
    load0_two(8'h11, 8'h12, 8'h34);
    check_output("post_rst_acc0", 32'(acc0), 32'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
